// File: rtl/lighting_pkg.sv
// Shared definitions for the lighting power scheduler.
//   sched_state_e : scheduler state encoding (IDLE / ACTIVE / STAGGER)
//   clog2_w()     : bits needed to index or count 'value' items, never less than 1
package lighting_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACTIVE  = 2'b01,
        STAGGER = 2'b10
    } sched_state_e;

    function automatic int unsigned clog2_w(input int unsigned value);
        int unsigned w;
        w = 0;
        while ((64'd1 << w) < 64'(value)) begin
            w++;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/zone_power_scheduler_if.sv
// Request/grant bundle between the per-zone lighting FSMs and the scheduler.
//   req          : per-zone light request (level)
//   manual_force : per-zone manual override, implies req and is served first
//   grant        : registered lamp enable per zone
//   on_count     : popcount of grant
//   overload     : request pending while the budget is full
//   busy         : stagger counter nonzero
// master = zone controllers side, slave = scheduler side.
interface zone_power_scheduler_if
    import lighting_pkg::*;
#(
    parameter int unsigned NUM_ZONES = 4
);
    localparam int unsigned CW = clog2_w(NUM_ZONES + 1);

    logic [NUM_ZONES-1:0] req;
    logic [NUM_ZONES-1:0] manual_force;
    logic [NUM_ZONES-1:0] grant;
    logic [CW-1:0]        on_count;
    logic                 overload;
    logic                 busy;

    modport master (
        output req, manual_force,
        input  grant, on_count, overload, busy
    );

    modport slave (
        input  req, manual_force,
        output grant, on_count, overload, busy
    );

endinterface

// File: rtl/zone_hold_timer.sv
// Minimum on-time timer for one zone.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : zone is being granted this edge; restart the hold window
//   grant        : current registered grant of this zone
//   expired      : hold window has elapsed (timer is 0)
module zone_hold_timer
    import lighting_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic grant,
    output logic expired
);
    localparam int unsigned TW = clog2_w(HOLD_CYCLES);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = TW'(HOLD_CYCLES - 1);
        end else if (!grant) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/zone_power_scheduler.sv
// Shares a lighting power budget among NUM_ZONES zones: at most MAX_ON lamps on,
// one new turn-on per GAP_CYCLES+1 edges, HOLD_CYCLES minimum on-time, and manual
// force requests served first (pre-empting an expired ordinary grant if needed).
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : request/grant bundle (slave side)
module zone_power_scheduler
    import lighting_pkg::*;
#(
    parameter int unsigned NUM_ZONES   = 4,
    parameter int unsigned MAX_ON      = 2,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input logic                   clk,
    input logic                   reset_n,
    zone_power_scheduler_if.slave bus
);
    localparam int unsigned CW = clog2_w(NUM_ZONES + 1);
    localparam int unsigned IW = clog2_w(NUM_ZONES);
    localparam int unsigned SW = clog2_w(GAP_CYCLES + 1);
    localparam logic [CW-1:0] MAX_ON_C = CW'(MAX_ON);

    function automatic logic [CW-1:0] popcount(input logic [NUM_ZONES-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_ZONES; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    logic [NUM_ZONES-1:0] grant_q, grant_d;
    logic [CW-1:0]        on_count_q, on_count_d;
    logic                 overload_q, overload_d;
    logic [SW-1:0]        stagger_q, stagger_d;
    logic [IW-1:0]        rr_q, rr_d;
    sched_state_e         state_q, state_d;

    logic [NUM_ZONES-1:0] want, pending, expired, releasing, kept;
    logic [NUM_ZONES-1:0] force_pend, revocable, load;
    logic [CW-1:0]        kept_cnt;
    logic                 room, preempt_ok, turn_on;
    logic                 force_found, rr_found;
    logic [IW-1:0]        force_idx, rr_idx, rev_idx, sel_idx, pos;

    // Force wins over an X or a simultaneous req because want ORs them.
    assign want       = bus.req | bus.manual_force;
    assign pending    = want & ~grant_q;
    assign releasing  = grant_q & ~want & expired;
    assign kept       = grant_q & ~releasing;
    assign kept_cnt   = popcount(kept);
    assign room       = (kept_cnt < MAX_ON_C);
    assign force_pend = pending & bus.manual_force;
    // Only expired ordinary grants can be taken away by a force request.
    assign revocable  = kept & ~bus.manual_force & expired;
    assign preempt_ok = !room && (force_pend != '0) && (revocable != '0);
    assign turn_on    = (stagger_q == '0) && ((room && (pending != '0)) || preempt_ok);

    // Descending loops leave the lowest index / earliest round-robin hit last.
    always_comb begin
        force_found = 1'b0;
        force_idx   = '0;
        rev_idx     = '0;
        rr_found    = 1'b0;
        rr_idx      = '0;
        pos         = '0;
        for (int i = NUM_ZONES - 1; i >= 0; i--) begin
            if (force_pend[i]) begin
                force_found = 1'b1;
                force_idx   = IW'(i);
            end
            if (revocable[i]) begin
                rev_idx = IW'(i);
            end
        end
        for (int k = NUM_ZONES - 1; k >= 0; k--) begin
            pos = IW'((int'(rr_q) + k) % NUM_ZONES);
            if (pending[pos]) begin
                rr_found = 1'b1;
                rr_idx   = pos;
            end
        end
        sel_idx = force_found ? force_idx : rr_idx;
    end

    always_comb begin
        grant_d   = kept;
        load      = '0;
        rr_d      = rr_q;
        stagger_d = (stagger_q != '0) ? stagger_q - 1'b1 : '0;
        if (turn_on) begin
            grant_d[sel_idx] = 1'b1;
            load[sel_idx]    = 1'b1;
            // A turn-on with no room left is a pre-emption.
            if (!room) begin
                grant_d[rev_idx] = 1'b0;
            end
            rr_d      = (sel_idx == IW'(NUM_ZONES - 1)) ? '0 : sel_idx + 1'b1;
            stagger_d = SW'(GAP_CYCLES);
        end
        on_count_d = popcount(grant_d);
        // Blocked by budget only; a pending stagger wait is not an overload.
        overload_d = (pending != '0) && !room && !preempt_ok;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (turn_on) begin
                    state_d = (GAP_CYCLES > 0) ? STAGGER : ACTIVE;
                end
            end
            ACTIVE: begin
                if (turn_on && (GAP_CYCLES > 0)) begin
                    state_d = STAGGER;
                end else if ((grant_d == '0) && ((want & ~grant_d) == '0)) begin
                    state_d = IDLE;
                end
            end
            STAGGER: begin
                if (stagger_d == '0) begin
                    state_d = ACTIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar i = 0; i < NUM_ZONES; i++) begin : g_timer
        zone_hold_timer #(
            .HOLD_CYCLES(HOLD_CYCLES)
        ) u_timer (
            .clk    (clk),
            .reset_n(reset_n),
            .load   (load[i]),
            .grant  (grant_q[i]),
            .expired(expired[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q    <= '0;
            on_count_q <= '0;
            overload_q <= 1'b0;
            stagger_q  <= '0;
            rr_q       <= '0;
            state_q    <= IDLE;
        end else begin
            grant_q    <= grant_d;
            on_count_q <= on_count_d;
            overload_q <= overload_d;
            stagger_q  <= stagger_d;
            rr_q       <= rr_d;
            state_q    <= state_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.on_count = on_count_q;
    assign bus.overload = overload_q;
    assign bus.busy     = (stagger_q != '0);

endmodule

// File: tb/tb_zone_power_scheduler.sv
// Self-checking bench for zone_power_scheduler (4 zones, MAX_ON=2, HOLD=16, GAP=2):
// directed scenarios with absolute expectations plus randomized traffic, all compared
// every cycle against a rule-level reference model.
module tb_zone_power_scheduler;
    localparam int NZ   = 4;
    localparam int MAXN = 2;
    localparam int HOLD = 16;
    localparam int GAP  = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    zone_power_scheduler_if #(.NUM_ZONES(NZ)) bus ();

    zone_power_scheduler #(
        .NUM_ZONES  (NZ),
        .MAX_ON     (MAXN),
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Reference model state: which zones are lit, remaining hold per zone,
    // edges left before the next turn-on, round-robin start, overload flag.
    bit m_on[NZ];
    int m_hold[NZ];
    int m_wait;
    int m_rr;
    bit m_ovl;

    task automatic model_reset();
        for (int i = 0; i < NZ; i++) begin
            m_on[i]   = 1'b0;
            m_hold[i] = 0;
        end
        m_wait = 0;
        m_rr   = 0;
        m_ovl  = 1'b0;
    endtask

    task automatic model_step();
        bit want[NZ];
        bit stay[NZ];
        int lit;
        int rr_order[$];
        int forced[$];
        int victim;
        int pick;
        bit can_preempt;
        lit = 0;
        for (int i = 0; i < NZ; i++) begin
            want[i] = bus.req[i] | bus.manual_force[i];
            stay[i] = m_on[i] && (want[i] || m_hold[i] > 0);
            if (stay[i]) lit++;
        end
        for (int k = 0; k < NZ; k++) begin
            int z;
            z = (m_rr + k) % NZ;
            if (want[z] && !m_on[z]) rr_order.push_back(z);
        end
        for (int i = 0; i < NZ; i++)
            if (want[i] && !m_on[i] && bus.manual_force[i]) forced.push_back(i);
        victim = -1;
        for (int i = 0; i < NZ && victim < 0; i++)
            if (stay[i] && !bus.manual_force[i] && m_hold[i] == 0) victim = i;
        can_preempt = (lit >= MAXN) && (forced.size() > 0) && (victim >= 0);
        pick = -1;
        if (m_wait == 0) begin
            if (lit < MAXN && rr_order.size() > 0) begin
                pick = (forced.size() > 0) ? forced[0] : rr_order[0];
            end else if (can_preempt) begin
                pick = forced[0];
                stay[victim] = 1'b0;
            end
        end
        m_ovl = (rr_order.size() > 0) && (lit >= MAXN) && !can_preempt;
        for (int i = 0; i < NZ; i++) begin
            if (i == pick) begin
                m_on[i]   = 1'b1;
                m_hold[i] = HOLD - 1;
            end else if (stay[i]) begin
                m_on[i]   = 1'b1;
                m_hold[i] = (m_hold[i] > 0) ? m_hold[i] - 1 : 0;
            end else begin
                m_on[i]   = 1'b0;
                m_hold[i] = 0;
            end
        end
        if (pick >= 0) begin
            m_rr   = (pick + 1) % NZ;
            m_wait = GAP;
        end else if (m_wait > 0) begin
            m_wait = m_wait - 1;
        end
    endtask

    function automatic logic [NZ-1:0] model_grant();
        logic [NZ-1:0] g;
        for (int i = 0; i < NZ; i++) g[i] = m_on[i];
        return g;
    endfunction

    function automatic int model_count();
        int n;
        n = 0;
        for (int i = 0; i < NZ; i++) if (m_on[i]) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("m_grant", 32'(bus.grant), 32'(model_grant()));
        chk("m_on_count", 32'(bus.on_count), 32'(model_count()));
        chk("m_overload", 32'(bus.overload), 32'(m_ovl));
        chk("m_busy", 32'(bus.busy), 32'(m_wait != 0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        bus.req          = '0;
        bus.manual_force = '0;
        reset_n          = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bus.req          = '0;
        bus.manual_force = '0;
        model_reset();
        #12;
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_on_count", 32'(bus.on_count), 32'h0);
        chk("rst_overload", 32'(bus.overload), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Stagger: second lamp three edges after the first.
        bus.req = 4'b0011;
        tick();
        chk("stg_grant_e1", 32'(bus.grant), 32'h1);
        chk("stg_busy_e1", 32'(bus.busy), 32'h1);
        tick();
        chk("stg_busy_e2", 32'(bus.busy), 32'h1);
        tick();
        chk("stg_busy_e3", 32'(bus.busy), 32'h0);
        chk("stg_grant_e3", 32'(bus.grant), 32'h1);
        tick();
        chk("stg_grant_e4", 32'(bus.grant), 32'h3);
        chk("stg_count_e4", 32'(bus.on_count), 32'h2);
        repeat (2) tick();

        // Asynchronous reset between edges, no clock needed.
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_grant", 32'(bus.grant), 32'h0);
        chk("arst_on_count", 32'(bus.on_count), 32'h0);
        chk("arst_busy", 32'(bus.busy), 32'h0);
        chk("arst_overload", 32'(bus.overload), 32'h0);
        model_reset();
        do_reset();

        // Minimum hold after a one-cycle request pulse.
        bus.req = 4'b0001;
        tick();
        chk("hold_e1", 32'(bus.grant), 32'h1);
        bus.req = 4'b0000;
        for (int e = 2; e <= 16; e++) begin
            tick();
            chk("hold_mid", 32'(bus.grant), 32'h1);
        end
        tick();
        chk("hold_e17", 32'(bus.grant), 32'h0);
        do_reset();

        // Budget limit and round-robin hand-over.
        bus.req = 4'b1111;
        tick();
        chk("bud_e1", 32'(bus.grant), 32'h1);
        repeat (3) tick();
        chk("bud_e4", 32'(bus.grant), 32'h3);
        for (int e = 5; e <= 10; e++) begin
            tick();
            chk("bud_overload", 32'(bus.overload), 32'h1);
            chk("bud_grant", 32'(bus.grant), 32'h3);
        end
        repeat (12) tick();
        bus.req = 4'b1110;
        tick();
        chk("rr_zone2", 32'(bus.grant), 32'h6);
        chk("rr_busy", 32'(bus.busy), 32'h1);
        bus.req = 4'b1111;
        repeat (3) tick();
        bus.req = 4'b1101;
        tick();
        chk("rr_zone3", 32'(bus.grant), 32'hC);
        bus.req = 4'b1011;
        repeat (11) tick();
        chk("rr_hold_z2", 32'(bus.grant), 32'hC);
        tick();
        chk("rr_zone0", 32'(bus.grant), 32'h9);
        do_reset();

        // Force pre-emption of an expired ordinary grant.
        bus.req = 4'b1011;
        tick();
        repeat (3) tick();
        chk("pre_setup", 32'(bus.grant), 32'h3);
        tick();
        chk("pre_ovl_before", 32'(bus.overload), 32'h1);
        repeat (20) tick();
        bus.manual_force = 4'b1000;
        tick();
        chk("pre_grant", 32'(bus.grant), 32'hA);
        chk("pre_busy", 32'(bus.busy), 32'h1);
        chk("pre_overload", 32'(bus.overload), 32'h0);
        chk("pre_count", 32'(bus.on_count), 32'h2);
        repeat (4) tick();
        do_reset();

        // Randomized traffic with sticky requests and occasional forces.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
            if ($urandom_range(0, 15) == 0) bus.manual_force = 4'(1 << $urandom_range(0, 3));
            else if ($urandom_range(0, 5) == 0) bus.manual_force = '0;
            tick();
            chk("rnd_max_on", 32'(bus.on_count <= MAXN), 32'h1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
